// File: rtl/seg_scan_if.sv
// seg_scan_if -- bundle between game logic / shared hex decoder and seg_scan_ctrl.
//
// Signals:
//   load        frame write request (accepted only while ready=1)
//   load_value  nibble per digit, digit k = bits [4k+3:4k]
//   load_blank  1 = digit k dark
//   load_dp     1 = decimal point k lit
//   ready       1 = no frame pending
//   hex_out     nibble presented to the shared decoder
//   seg_in      active-low decoder output (bit 7 = dp position)
//   seg_out     active-low segments to pins
//   an          active-low anode enables, at most one low
//
// The master side is whatever sits around the controller: game logic drives the
// load bus and the shared decoder drives seg_in back.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_value;
    logic [NUM_DIGITS-1:0]   load_blank;
    logic [NUM_DIGITS-1:0]   load_dp;
    logic                    ready;
    logic [3:0]              hex_out;
    logic [7:0]              seg_in;
    logic [7:0]              seg_out;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output load, load_value, load_blank, load_dp, seg_in,
        input  ready, hex_out, seg_out, an
    );

    modport slave (
        input  load, load_value, load_blank, load_dp, seg_in,
        output ready, hex_out, seg_out, an
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- time-multiplexed scan controller for a common-anode
// seven-segment bank sharing one hex-to-segment decoder.
//
// Each digit slot is REFRESH_DIV cycles: BLANK_CYCLES of all-anodes-off guard
// followed by the ON time. A frame written through load/ready is held in a
// shadow copy and only becomes active at the guard exit that wraps back to
// digit 0, so a frame is never displayed half old / half new.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    seg_scan_if.slave (load bus, ready, hex_out, seg_in, seg_out, an)
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input logic       clk,
    input logic       rst_n,
    seg_scan_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] GUARD_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        GUARD = 1'b0,
        ON    = 1'b1
    } state_t;

    state_t                state_reg;
    logic [CW-1:0]         cnt_reg;
    logic [IW-1:0]         idx_reg;
    logic                  pending_reg;
    logic [NUM_DIGITS-1:0] an_reg;
    logic [3:0]            hex_reg;

    logic [3:0]            active_value_reg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] active_blank_reg;
    logic [NUM_DIGITS-1:0] active_dp_reg;
    logic [3:0]            shadow_value_reg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] shadow_blank_reg;
    logic [NUM_DIGITS-1:0] shadow_dp_reg;

    // Split the flat load bus into one nibble per digit.
    logic [3:0] load_nib [NUM_DIGITS];
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
        assign load_nib[gi] = bus.load_value[4*gi +: 4];
    end

    logic [IW-1:0] idx_next;
    logic          guard_exit;
    logic          commit;
    logic          load_accept;

    assign idx_next    = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    assign guard_exit  = (state_reg == GUARD) && (cnt_reg == GUARD_LAST);
    // Frame boundary: leaving the guard that precedes digit 0.
    assign commit      = guard_exit && (idx_reg == IDX_LAST) && pending_reg;
    // ready is ~pending, so a load in the commit cycle is never accepted and
    // the shadow cannot be overwritten while it is being copied.
    assign load_accept = bus.load && !pending_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= GUARD;
            cnt_reg          <= '0;
            idx_reg          <= IDX_LAST;
            pending_reg      <= 1'b0;
            an_reg           <= '1;
            hex_reg          <= '0;
            active_blank_reg <= '1;
            active_dp_reg    <= '0;
            shadow_blank_reg <= '0;
            shadow_dp_reg    <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                active_value_reg[k] <= '0;
                shadow_value_reg[k] <= '0;
            end
        end else begin
            if (load_accept) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    shadow_value_reg[k] <= load_nib[k];
                end
                shadow_blank_reg <= bus.load_blank;
                shadow_dp_reg    <= bus.load_dp;
                pending_reg      <= 1'b1;
            end

            case (state_reg)
                GUARD: begin
                    if (guard_exit) begin
                        state_reg <= ON;
                        cnt_reg   <= '0;
                        idx_reg   <= idx_next;
                        an_reg    <= ~(NUM_DIGITS'(1) << idx_next);
                        // On a commit the wrapped digit is 0 and must come
                        // from the frame being committed this very edge.
                        hex_reg   <= commit ? shadow_value_reg[0]
                                            : active_value_reg[idx_next];
                        if (commit) begin
                            for (int k = 0; k < NUM_DIGITS; k++) begin
                                active_value_reg[k] <= shadow_value_reg[k];
                            end
                            active_blank_reg <= shadow_blank_reg;
                            active_dp_reg    <= shadow_dp_reg;
                            pending_reg      <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ON: begin
                    if (cnt_reg == ON_LAST) begin
                        state_reg <= GUARD;
                        cnt_reg   <= '0;
                        an_reg    <= '1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= GUARD;
                    cnt_reg   <= '0;
                    an_reg    <= '1;
                end
            endcase
        end
    end

    // Segment gating stays combinational so the decoder round trip
    // (hex_out -> seg_in -> seg_out) adds no cycle of latency.
    always_comb begin
        bus.seg_out = 8'hFF;
        if (state_reg == ON) begin
            bus.seg_out[6:0] = active_blank_reg[idx_reg] ? 7'h7F : bus.seg_in[6:0];
            bus.seg_out[7]   = ~(active_dp_reg[idx_reg] & ~active_blank_reg[idx_reg]);
        end
    end

    assign bus.ready   = ~pending_reg;
    assign bus.an      = an_reg;
    assign bus.hex_out = hex_reg;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FR = ND * RD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(ND)) bus();

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0] an;
        logic [3:0] hex;
        logic [7:0] seg;
        logic       rdy;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: position in the scan is pure arithmetic on c, the
    // number of rising edges since reset release.
    int          c       = 0;
    bit          in_rst  = 1'b1;
    bit          pend    = 1'b0;
    logic [15:0] a_val   = 16'h0;
    logic [15:0] s_val   = 16'h0;
    logic [3:0]  a_blk   = 4'hF;
    logic [3:0]  s_blk   = 4'h0;
    logic [3:0]  a_dp    = 4'h0;
    logic [3:0]  s_dp    = 4'h0;
    logic [3:0]  last_hex = 4'h0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic push_expected();
        exp_t       e;
        logic [3:0] one;
        int         d;
        one   = 4'b0001;
        e.an  = 4'hF;
        e.seg = 8'hFF;
        e.hex = last_hex;
        e.rdy = !pend;
        if (!in_rst && (c % RD) >= BC) begin
            d          = (c / RD) % ND;
            e.an       = ~(one << d);
            e.seg[6:0] = a_blk[d] ? 7'h7F : bus.seg_in[6:0];
            e.seg[7]   = ~(a_dp[d] & ~a_blk[d]);
        end
        sb.push_back(e);
    endtask

    // One clock: apply the model's edge update with what the DUT saw, then
    // drive the next inputs and queue the expected outputs for that cycle.
    task automatic step(input bit nload, input logic [15:0] v, input logic [3:0] b,
                        input logic [3:0] dp, input bit nrst);
        @(posedge clk);
        if (!in_rst) begin
            c++;
            if ((c % FR) == BC && pend) begin
                a_val = s_val; a_blk = s_blk; a_dp = s_dp; pend = 1'b0;
            end else if (bus.load && !pend) begin
                s_val = bus.load_value; s_blk = bus.load_blank; s_dp = bus.load_dp;
                pend  = 1'b1;
            end
            if ((c % RD) == BC) last_hex = a_val[4*((c / RD) % ND) +: 4];
        end
        #1;
        bus.load       = nload;
        bus.load_value = v;
        bus.load_blank = b;
        bus.load_dp    = dp;
        bus.seg_in     = 8'($urandom);
        if (!nrst) begin
            rst_n = 1'b0; in_rst = 1'b1; pend = 1'b0;
            a_val = 16'h0; a_blk = 4'hF; a_dp = 4'h0; last_hex = 4'h0;
        end else if (in_rst) begin
            rst_n = 1'b1; in_rst = 1'b0; c = 0;
        end
        push_expected();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'h0, 4'h0, 4'h0, 1'b1);
    endtask

    // Scoreboard monitor: one expected entry per presented cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("an", 8'(bus.an), 8'(e.an));
                chk("hex_out", 8'(bus.hex_out), 8'(e.hex));
                chk("seg_out", bus.seg_out, e.seg);
                chk("ready", 8'(bus.ready), 8'(e.rdy));
            end
        end
    end

    // Guard integrity: one anode at most, and >= BC all-off cycles between ONs.
    initial begin
        logic [3:0] prev_an;
        int         off_run;
        bit         seen_on;
        prev_an = 4'hF; off_run = 0; seen_on = 1'b0;
        forever begin
            @(negedge clk);
            total++;
            if ($countones(~bus.an) > 1) begin
                bad++;
                $display("FAIL an_onehot: actual=%b required=at most one low", bus.an);
            end
            if (bus.an != 4'hF) begin
                if (prev_an == 4'hF && seen_on) begin
                    total++;
                    if (off_run < BC) begin
                        bad++;
                        $display("FAIL guard_gap: actual=%0d required>=%0d", off_run, BC);
                    end
                end
                if (prev_an != 4'hF && prev_an != bus.an) begin
                    total++; bad++;
                    $display("FAIL anode_overlap: actual=%b required=%b", bus.an, prev_an);
                end
                seen_on = 1'b1;
                off_run = 0;
            end else begin
                off_run++;
            end
            prev_an = bus.an;
        end
    end

    initial begin
        bus.load = 1'b0; bus.load_value = 16'h0; bus.load_blank = 4'h0;
        bus.load_dp = 4'h0; bus.seg_in = 8'hFF;

        // Reset held, then released; slot timing from release.
        repeat (3) step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        idle(1);
        while (c < 11) idle(1);

        // Frame load during digit 1 ON, then a busy load that must be ignored.
        step(1'b1, 16'h4321, 4'h0, 4'b0100, 1'b1);
        step(1'b1, 16'hFFFF, 4'h0, 4'h0, 1'b1);
        while (c < 80) idle(1);

        // Blanking of digit 3.
        step(1'b1, 16'hABCD, 4'b1000, 4'h0, 1'b1);
        idle(70);

        // Reset pulse while a frame is pending: it must never appear.
        step(1'b1, 16'h5A5A, 4'h0, 4'hF, 1'b1);
        idle(3);
        step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        idle(80);

        // Randomized traffic, including loads that land in busy/commit cycles.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 199) == 0)
                step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
            else
                step($urandom_range(0, 5) == 0, 16'($urandom), 4'($urandom),
                     4'($urandom), 1'b1);
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: actual=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
